// File: rtl/cache_pkg.sv
// Shared definitions for the cache way-select / LRU block: default geometry,
// per-way entry field offsets and the registered lookup response.
package cache_pkg;

    localparam int WAYS_DEF  = 4;
    localparam int TAG_W_DEF = 23;
    localparam int SETS_DEF  = 16;

    // Way indices are carried at the widest legal size (8 ways); the top trims them.
    localparam int WAY_IDX_W = 3;

    // Each way slice of entries_i is {valid, dirty, tag} with the tag in the LSBs.
    localparam int ENT_TAG_OFS = 0;

    function automatic int ent_dirty_ofs(input int tag_w);
        return tag_w;
    endfunction

    function automatic int ent_valid_ofs(input int tag_w);
        return tag_w + 1;
    endfunction

    typedef struct packed {
        logic                 hit;
        logic [WAY_IDX_W-1:0] hit_way;
        logic                 multi_hit;
        logic [WAY_IDX_W-1:0] victim_way;
        logic                 victim_dirty;
    } lookup_resp_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } lru_state_e;

endpackage

// File: rtl/way_prio_enc.sv
// Lowest-index priority encoder over a one-hot-or-more request vector.
module way_prio_enc #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic         any_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/way_select_lru.sv
// Tag compare, hit/victim selection and true-LRU age tracking per set.
// Optional hit/miss counters are built when WAY_SELECT_LRU_STATS_EN is defined.
module way_select_lru
    import cache_pkg::*;
#(
    parameter int WAYS  = WAYS_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int SETS  = SETS_DEF
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [$clog2(SETS)-1:0]         req_set_i,
    input  logic [TAG_W-1:0]                req_tag_i,
    input  logic [WAYS*(TAG_W+2)-1:0]       entries_i,
    input  logic                            fill_valid_i,
    input  logic [$clog2(SETS)-1:0]         fill_set_i,
    input  logic [$clog2(WAYS)-1:0]         fill_way_i,
    output logic                            resp_valid_o,
    output logic                            hit_o,
    output logic [$clog2(WAYS)-1:0]         hit_way_o,
    output logic                            multi_hit_o,
    output logic [$clog2(WAYS)-1:0]         victim_way_o,
    output logic                            victim_dirty_o
`ifdef WAY_SELECT_LRU_STATS_EN
    ,
    output logic [31:0]                     hit_cnt_o,
    output logic [31:0]                     miss_cnt_o
`endif
);

    localparam int WW        = $clog2(WAYS);
    localparam int SW        = $clog2(SETS);
    localparam int EW        = TAG_W + 2;
    localparam int DIRTY_OFS = ent_dirty_ofs(TAG_W);
    localparam int VALID_OFS = ent_valid_ofs(TAG_W);

    lru_state_e state_q, state_d;
    logic [SW-1:0] sweep_q, sweep_d;
    logic [WAYS-1:0][WW-1:0] age_q [SETS];

    logic [WAYS-1:0] match, invalid, dirty;
    logic            hit_any, inv_any, multi_hit, accept;
    logic [WW-1:0]   hit_idx, inv_idx, lru_idx, victim_idx;

    logic                    upd_en;
    logic [SW-1:0]           upd_set;
    logic [WW-1:0]           upd_way;
    logic [WAYS-1:0][WW-1:0] upd_cur, upd_new;

    logic         resp_valid_q;
    lookup_resp_t resp_d, resp_q;
    logic         unused_resp_bits;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + SW'(1);
            if (sweep_q == SW'(SETS - 1)) state_d = ST_RUN;
        end
    end

    assign req_ready_o = (state_q == ST_RUN) & ~rst_i;
    assign accept      = req_valid_i & req_ready_o;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign invalid[w] = ~entries_i[w*EW + VALID_OFS];
        assign dirty[w]   = entries_i[w*EW + DIRTY_OFS];
        assign match[w]   = entries_i[w*EW + VALID_OFS] &
                            (entries_i[w*EW + ENT_TAG_OFS +: TAG_W] == req_tag_i);
    end

    way_prio_enc #(.N(WAYS), .W(WW)) u_hit_enc (
        .req_i (match),
        .any_o (hit_any),
        .idx_o (hit_idx)
    );

    way_prio_enc #(.N(WAYS), .W(WW)) u_inv_enc (
        .req_i (invalid),
        .any_o (inv_any),
        .idx_o (inv_idx)
    );

    // Oldest way of the looked-up set; ages are a permutation so exactly one matches.
    always_comb begin
        lru_idx = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[req_set_i][w] == WW'(WAYS - 1)) lru_idx = WW'(w);
        end
    end

    assign victim_idx = inv_any ? inv_idx : lru_idx;
    assign multi_hit  = |(match & (match - WAYS'(1)));

    always_comb begin
        resp_d              = '0;
        resp_d.hit          = hit_any;
        resp_d.hit_way      = WAY_IDX_W'(hit_idx);
        resp_d.multi_hit    = multi_hit;
        resp_d.victim_way   = WAY_IDX_W'(victim_idx);
        resp_d.victim_dirty = dirty[victim_idx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            resp_valid_q <= accept;
            if (accept) resp_q <= resp_d;
        end
    end

    assign resp_valid_o   = resp_valid_q;
    assign hit_o          = resp_q.hit;
    assign hit_way_o      = resp_q.hit_way[WW-1:0];
    assign multi_hit_o    = resp_q.multi_hit;
    assign victim_way_o   = resp_q.victim_way[WW-1:0];
    assign victim_dirty_o = resp_q.victim_dirty;
    assign unused_resp_bits = ^{resp_q.hit_way, resp_q.victim_way};

    // A fill owns the single update slot; a coincident lookup hit loses its update.
    always_comb begin
        upd_en  = 1'b0;
        upd_set = req_set_i;
        upd_way = hit_idx;
        if ((state_q == ST_RUN) && fill_valid_i) begin
            upd_en  = 1'b1;
            upd_set = fill_set_i;
            upd_way = fill_way_i;
        end else if (accept && hit_any) begin
            upd_en = 1'b1;
        end
    end

    assign upd_cur = age_q[upd_set];

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            if (WW'(w) == upd_way)
                upd_new[w] = '0;
            else if (upd_cur[w] < upd_cur[upd_way])
                upd_new[w] = upd_cur[w] + WW'(1);
            else
                upd_new[w] = upd_cur[w];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_INIT) begin
                for (int w = 0; w < WAYS; w++) age_q[sweep_q][w] <= WW'(w);
            end else if (upd_en) begin
                age_q[upd_set] <= upd_new;
            end
        end
    end

`ifdef WAY_SELECT_LRU_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (accept) begin
            if (hit_any && (hit_cnt_o != '1))
                hit_cnt_o <= hit_cnt_o + 32'd1;
            else if (!hit_any && (miss_cnt_o != '1))
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule
